// File: rtl/mac_bram_responder_pkg.sv
// mac_bram_responder_pkg: shared state encoding, word geometry and address helper
package mac_bram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    function automatic logic [29:0] byte_to_word(input logic [31:0] byte_addr);
        return 30'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/mac_bram_responder_dp_bram_be.sv
// dp_bram_be: true dual-port RAM, byte enables on port A, read-first on both ports
module dp_bram_be
    import mac_bram_responder_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [BE_W-1:0]   a_we,
    input  logic [WORD_W-1:0] a_wdata,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wdata,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // storage writes: byte lanes from port A, full words from port B; contents survive reset
    always_ff @(posedge aclk) begin
        for (int i = 0; i < BE_W; i++)
            if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        if (b_en && b_we) mem[b_addr] <= b_wdata;
    end

    // read registers sample the pre-write contents; port B only updates on a read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            if (b_en && !b_we) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/mac_bram_responder.sv
// mac_bram_responder: PE-side vector memory, host load/readback port and run control
module mac_bram_responder
    import mac_bram_responder_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int RESULT_WORD = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       BRAM_ADDR,
    input  logic [WORD_W-1:0] BRAM_WRDATA,
    input  logic [BE_W-1:0]   BRAM_WE,
    output logic [WORD_W-1:0] BRAM_RDDATA,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [WORD_W-1:0] host_rdata,
    input  logic              host_start,
    output logic              start,
    input  logic              pe_done,
    output logic              busy,
    output logic [WORD_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              timeout,
    output logic              pe_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] idx;
    logic              host_acc, cnt_zero, res_hit;

    assign idx          = ADDR_W'(byte_to_word(BRAM_ADDR));
    // gated by aresetn so every output reads 0 while reset is held
    assign host_ready   = aresetn && state != S_RUN;
    assign host_acc     = host_valid && host_ready;
    assign busy         = state == S_RUN;
    assign result_valid = state == S_RESULT;
    assign cnt_zero     = cnt == '0;
    assign res_hit      = BRAM_WE == 4'hF && idx == ADDR_W'(RESULT_WORD);

    dp_bram_be #(.ADDR_W(ADDR_W)) u_ram (
        .aclk    (aclk),
        .aresetn (aresetn),
        .a_addr  (idx),
        .a_we    (busy ? BRAM_WE : '0),
        .a_wdata (BRAM_WRDATA),
        .a_rdata (BRAM_RDDATA),
        .b_en    (host_acc),
        .b_we    (host_we),
        .b_addr  (host_addr),
        .b_wdata (host_wdata),
        .b_rdata (host_rdata)
    );

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nx;
    end

    // next state; start fires in the idle cycle that accepts host_start
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        unique case (state)
            S_IDLE: begin
                start    = aresetn && host_start;
                state_nx = host_start ? S_RUN : S_IDLE;
            end
            S_RUN:    state_nx = (pe_done || cnt_zero) ? S_RESULT : S_RUN;
            S_RESULT: state_nx = result_ack ? S_IDLE : S_RESULT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // timeout counter, result capture, sticky status and host read strobe
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt         <= '0;
            result      <= '0;
            timeout     <= 1'b0;
            pe_err      <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_acc && !host_we;
            if (start) begin
                cnt     <= CW'(TIMEOUT_CYC - 1);
                result  <= '0;
                timeout <= 1'b0;
                pe_err  <= 1'b0;
            end else if (busy) begin
                if (!cnt_zero) cnt <= cnt - CW'(1);
                if (res_hit) result <= BRAM_WRDATA;
                if (cnt_zero && !pe_done) timeout <= 1'b1;
            end else if (|BRAM_WE) begin
                pe_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_bram_responder.sv
// tb_mac_bram_responder: vector table, host read scoreboard and run sequences
module tb_mac_bram_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] BRAM_ADDR = '0, BRAM_WRDATA = '0, BRAM_RDDATA;
    logic [3:0]  BRAM_WE = '0;
    logic        host_valid = 1'b0, host_we = 1'b0, host_ready, host_rvalid;
    logic [4:0]  host_addr = '0;
    logic [31:0] host_wdata = '0, host_rdata, result;
    logic        host_start = 1'b0, start, pe_done = 1'b0, busy;
    logic        result_valid, result_ack = 1'b0, timeout, pe_err;

    int          n_chk = 0, n_fail = 0, cyc;
    logic [31:0] model [32];
    logic [31:0] sb_q [$];
    logic [31:0] sb_exp;

    typedef struct {
        logic [31:0] baddr;
        logic [31:0] exp;
    } pe_vec_t;
    pe_vec_t pv [4];

    always #5 aclk = ~aclk;

    mac_bram_responder #(.ADDR_W(5), .RESULT_WORD(0), .TIMEOUT_CYC(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE), .BRAM_RDDATA(BRAM_RDDATA),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_start(host_start), .start(start), .pe_done(pe_done), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .timeout(timeout), .pe_err(pe_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {BRAM_RDDATA, host_rdata, result, host_ready, host_rvalid, start, busy,
                result_valid, timeout, pe_err};
    endfunction

    task automatic host_write(input int a, input logic [31:0] d);
        @(negedge aclk);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 5'(a); host_wdata = d;
        @(negedge aclk);
        host_valid = 1'b0; host_we = 1'b0;
        model[a] = d;
    endtask

    task automatic host_read(input int a);
        @(negedge aclk);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 5'(a);
        sb_q.push_back(model[a]);
        @(negedge aclk);
        host_valid = 1'b0;
        check("rvalid_latency", host_rvalid, 1);
    endtask

    task automatic run_start();
        @(negedge aclk);
        host_start = 1'b1;
        #1 check("start_high", start, 1);
        @(negedge aclk);
        host_start = 1'b0;
        #1 check("start_single", start, 0);
        check("run_busy", {busy, host_ready}, 2'b10);
    endtask

    task automatic ack();
        @(negedge aclk); result_ack = 1'b1;
        @(negedge aclk); result_ack = 1'b0;
        check("ack_idle", {result_valid, busy}, 2'b00);
    endtask

    // scoreboard: every host read response must match the oldest outstanding expectation
    always @(negedge aclk) begin
        if (host_rvalid) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: host_rvalid with no pending read, rdata %0h", host_rdata);
            end else begin
                sb_exp = sb_q.pop_front();
                if (host_rdata !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_host_rdata: got %0h expected %0h", host_rdata, sb_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pv[0] = '{32'h0000_0014, 32'h1000_0005};
        pv[1] = '{32'h0000_007C, 32'h1000_001F};
        pv[2] = '{32'hFFFF_FF80, 32'h1000_0000};
        pv[3] = '{32'h0000_0023, 32'h1000_0008};

        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #2 check("reset_outputs", all_outs(), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check("idle_ready", {host_ready, busy}, 2'b10);

        for (int i = 0; i < 32; i++) host_write(i, 32'h1000_0000 + i);
        host_read(7);
        @(negedge aclk);
        check("rdata_hold", {host_rvalid, host_rdata}, {1'b0, 32'h1000_0007});
        host_read(0);
        host_read(31);

        @(negedge aclk);
        BRAM_ADDR = pv[0].baddr;
        #1 check("pe_rd_not_early", BRAM_RDDATA, 32'h1000_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            BRAM_ADDR = pv[i].baddr;
            @(negedge aclk);
            check($sformatf("pe_rd_vec%0d", i), BRAM_RDDATA, pv[i].exp);
        end

        @(negedge aclk);
        BRAM_ADDR = 32'h14; BRAM_WE = 4'hF; BRAM_WRDATA = 32'hFFFF_FFFF;
        @(negedge aclk);
        BRAM_WE = 4'h0;
        check("pe_err_set", pe_err, 1);
        @(negedge aclk);
        check("idle_write_dropped", BRAM_RDDATA, 32'h1000_0005);
        host_read(5);

        run_start();
        check("run_clears", {pe_err, timeout, result}, 0);
        BRAM_ADDR = 32'h0; BRAM_WE = 4'hF; BRAM_WRDATA = 32'hDEAD_BEEF;
        @(negedge aclk);
        BRAM_WE = 4'h0;
        repeat (4) @(negedge aclk);
        check("run_busy_mid", {busy, host_ready}, 2'b10);
        pe_done = 1'b1;
        @(negedge aclk);
        pe_done = 1'b0;
        check("normal_done", {result_valid, busy, host_ready, timeout, result},
              {4'b1010, 32'hDEAD_BEEF});
        check("pe_mem0", BRAM_RDDATA, 32'hDEAD_BEEF);
        model[0] = 32'hDEAD_BEEF;
        host_read(0);
        ack();
        check("result_kept", result, 32'hDEAD_BEEF);

        run_start();
        check("result_cleared", result, 0);
        BRAM_ADDR = 32'h0C; BRAM_WE = 4'b0101; BRAM_WRDATA = 32'hAABB_CCDD;
        @(negedge aclk);
        BRAM_ADDR = 32'h0; BRAM_WE = 4'b0011; BRAM_WRDATA = 32'h1234_5678;
        @(negedge aclk);
        check("partial_no_capture", result, 0);
        BRAM_WE = 4'hF; BRAM_WRDATA = 32'h1111_1111;
        @(negedge aclk);
        check("full_capture", result, 32'h1111_1111);
        BRAM_WRDATA = 32'h2222_2222; pe_done = 1'b1;
        @(negedge aclk);
        BRAM_WE = 4'h0; pe_done = 1'b0;
        check("capture_with_done", {result_valid, timeout, result}, {2'b10, 32'h2222_2222});
        model[3] = 32'h10BB_00DD;
        model[0] = 32'h2222_2222;
        host_read(3);
        host_read(0);
        ack();

        run_start();
        repeat (15) @(negedge aclk);
        check("last_run_cycle", busy, 1);
        pe_done = 1'b1;
        @(negedge aclk);
        pe_done = 1'b0;
        check("done_at_zero", {result_valid, timeout}, 2'b10);
        ack();

        run_start();
        cyc = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            cyc++;
            @(negedge aclk);
        end
        check("timeout_cycles", cyc, 16);
        check("timeout_flag", {result_valid, timeout}, 2'b11);
        @(negedge aclk);
        host_start = 1'b1;
        #1 check("start_ignored", start, 0);
        @(negedge aclk);
        host_start = 1'b0;
        check("result_hold", {result_valid, busy, timeout}, 3'b101);
        ack();
        check("timeout_sticky", timeout, 1);

        run_start();
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 0);
        repeat (2) @(negedge aclk);
        check("no_restart", {start, busy}, 2'b00);
        aresetn = 1'b1;
        #1 check("post_reset_idle", {host_ready, busy, result_valid}, 3'b100);
        host_read(3);
        host_read(7);
        host_read(0);

        @(negedge aclk);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_bram_responder.md
Name: mac_bram_responder

Overview:
- BRAM-side responder for the MAC PE controller. It owns the vector memory that the controller reads its operands from and writes its result into.
- It also gives the host a word-level load/readback port, issues the run `start` pulse, and captures the result word and completion status.
- It sits between the host/AXI glue and the PE controller's BRAM_* master port.

Parameters:
- ADDR_W, 5, log2 of memory depth in 32-bit words (default 32 words).
- RESULT_WORD, 0, word index whose full-word PE write is captured as the result.
- TIMEOUT_CYC, 4096, max cycles in S_RUN before a forced timeout completion.

Ports:
- aclk  in  1  single clock for all logic and both memory ports.
- aresetn  in  1  asynchronous active-low reset.
- BRAM_ADDR  in  32  PE byte address; word index = BRAM_ADDR[ADDR_W+1:2], other bits ignored.
- BRAM_WRDATA  in  32  PE write data.
- BRAM_WE  in  4  PE byte-lane write enables.
- BRAM_RDDATA  out  32  PE read data, registered.
- host_valid  in  1  host request valid.
- host_ready  out  1  host request accepted when host_valid&&host_ready.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word index.
- host_wdata  in  32  host write data (full word).
- host_rvalid  out  1  one-cycle pulse; host_rdata valid.
- host_rdata  out  32  host read data.
- host_start  in  1  start request pulse.
- start  out  1  one-cycle start pulse to the PE controller.
- pe_done  in  1  done pulse from the PE controller.
- busy  out  1  high in S_RUN.
- result  out  32  captured result word.
- result_valid  out  1  high in S_RESULT.
- result_ack  in  1  host acknowledges the result.
- timeout  out  1  sticky: the last run ended by timeout.
- pe_err  out  1  sticky: a PE write arrived outside S_RUN.

Behaviour:
- Reset values (all outputs): 0, state S_IDLE. Memory contents are not reset.
- Memory organisation:
  - 2^ADDR_W x 32 true dual-port block RAM.
  - Port A is the PE side; port B is the host side.
- PE port:
  - Read latency is 1 cycle: BRAM_RDDATA <= mem[idx] on every clock, in every state.
  - Read-first: a same-cycle write to the same word returns the old data.
  - Writes apply per byte lane BRAM_WE[i] -> bits [8i+7:8i], in S_RUN only.
  - A nonzero BRAM_WE outside S_RUN is dropped and sets pe_err.
- Host port:
  - host_ready = (state != S_RUN).
  - Accepted write: mem[host_addr] <= host_wdata.
  - Accepted read: host_rvalid=1 and host_rdata=mem[host_addr] on the next cycle.
  - host_rdata holds its value otherwise.
- FSM:
  - S_IDLE: on host_start, assert start for exactly 1 cycle, clear timeout/pe_err/result, load the timeout counter with TIMEOUT_CYC-1, and go to S_RUN.
  - S_RUN:
    - A write with BRAM_WE==4'hF and idx==RESULT_WORD latches result <= BRAM_WRDATA. A later such write overwrites it.
    - Partial-lane writes to RESULT_WORD update memory only, not result.
    - pe_done -> S_RESULT.
    - Counter reaches 0 without pe_done -> S_RESULT and timeout=1.
    - pe_done and the counter reaching 0 in the same cycle count as a normal completion (timeout stays 0).
    - A write and pe_done in the same cycle: the write is captured.
  - S_RESULT: result_valid=1. On result_ack -> S_IDLE; result keeps its value until the next start.
- host_start is ignored outside S_IDLE. result_ack is ignored outside S_RESULT.
- host_start and an accepted host access in the same S_IDLE cycle: both occur; the host access completes normally.
- Reset asserted mid-run: everything returns to S_IDLE immediately, and start is never re-issued.
- busy = (state==S_RUN).

Decomposition:
- Shared package:
  - state encoding (S_IDLE/S_RUN/S_RESULT, 2-bit)
  - WORD_W=32 and BE_W=4 constants
  - function converting a byte address to a word index
- Sub-module dp_bram_be: true dual-port RAM with byte enables on port A, read-first on both ports, no reset.
- FSM, timeout counter and capture logic stay in the top.

Test Plan:
- Host load/readback:
  - Stimulus: host writes mem[i]=32'h1000_0000+i for i=0..31, then reads word 7.
  - Required: host_rvalid one cycle after acceptance with host_rdata=32'h1000_0007.
- PE read latency:
  - Stimulus: in S_IDLE, drive BRAM_ADDR=32'h0000_0014.
  - Required: BRAM_RDDATA=32'h1000_0005 exactly one cycle later.
  - Check: a PE write in this state is dropped, memory is unchanged, and pe_err=1.
- Normal run:
  - Stimulus: host_start pulse, then BRAM_WE=4'hF, BRAM_ADDR=0, BRAM_WRDATA=32'hDEAD_BEEF, and pe_done 5 cycles later.
  - Required: start pulses 1 cycle, busy high and host_ready low during the run, result=32'hDEAD_BEEF, result_valid=1, timeout=0, mem[0]=32'hDEAD_BEEF; result_ack returns to S_IDLE.
- Byte lanes:
  - Stimulus: in S_RUN, BRAM_WE=4'b0101 to word 3 holding 32'h1000_0003, with BRAM_WRDATA=32'hAABB_CCDD.
  - Required: mem[3]=32'h10BB_00DD and result unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, start, no pe_done.
  - Required: S_RESULT entered 16 cycles after start deasserts, timeout=1.
  - Check: host_start during S_RESULT is ignored.
- Reset mid-run:
  - Stimulus: assert aresetn=0 asynchronously in S_RUN.
  - Required: all outputs 0 with no clock edge needed, and memory contents preserved.
